// File: rtl/park_pkg.sv
// Shared definitions for the car-park ticketing/payment slice: exit FSM
// encodings and the default sizing/tariff values also used by the bar
// controller.
package park_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CALC     = 2'd1,
        WAIT_PAY = 2'd2,
        PAID     = 2'd3
    } fee_state_t;

    localparam int PARK_PMAX    = 5;
    localparam int PARK_RATE    = 2;
    localparam int PARK_FEE_MIN = 1;

endpackage

// File: rtl/park_slot_table.sv
// Per-slot occupancy table: valid bits and entry timestamps, lowest-free
// slot allocator, free-place count / full flag and a release port used when
// a payment completes. Allocation looks only at the pre-cycle valid bits, so
// a slot released this cycle becomes allocatable from the next cycle on.
module park_slot_table
    import park_pkg::*;
#(
    parameter int PMAX = PARK_PMAX,
    parameter int IDW  = 3,
    parameter int TW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_req,
    input  logic [TW-1:0]   now,
    input  logic            rel_en,
    input  logic [IDW-1:0]  rel_id,
    input  logic [IDW-1:0]  rd_id,
    output logic            alloc_ok,
    output logic [IDW-1:0]  alloc_id,
    output logic [PMAX-1:0] valid,
    output logic [TW-1:0]   rd_tstamp,
    output logic [IDW:0]    free_cnt,
    output logic            full
);

    logic [PMAX-1:0] valid_r;
    logic [PMAX-1:0] valid_nxt_s;
    logic [TW-1:0]   tstamp_r [PMAX];
    logic [IDW:0]    free_cnt_r;
    logic [IDW:0]    free_cnt_nxt_s;
    logic            full_r;
    logic            free_found_s;
    logic [IDW-1:0]  free_idx_s;
    logic            alloc_ok_s;

    // Priority encoder: the last hit of a descending scan is the lowest free slot.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = {IDW{1'b0}};
        for (int i = PMAX - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = IDW'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    assign alloc_ok_s = alloc_req & free_found_s;

    // Next valid vector and the free count derived from it, so both update together.
    always_comb begin
        valid_nxt_s    = valid_r;
        free_cnt_nxt_s = {(IDW + 1){1'b0}};
        if (rel_en) begin
            valid_nxt_s[rel_id] = 1'b0;
        end else begin
            valid_nxt_s = valid_nxt_s;
        end
        if (alloc_ok_s) begin
            valid_nxt_s[free_idx_s] = 1'b1;
        end else begin
            valid_nxt_s = valid_nxt_s;
        end
        for (int i = 0; i < PMAX; i++) begin
            if (!valid_nxt_s[i]) begin
                free_cnt_nxt_s = free_cnt_nxt_s + (IDW + 1)'(1);
            end else begin
                free_cnt_nxt_s = free_cnt_nxt_s;
            end
        end
    end

    // Table storage plus registered occupancy status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r    <= {PMAX{1'b0}};
            free_cnt_r <= (IDW + 1)'(PMAX);
            full_r     <= 1'b0;
            for (int i = 0; i < PMAX; i++) begin
                tstamp_r[i] <= {TW{1'b0}};
            end
        end else begin
            valid_r    <= valid_nxt_s;
            free_cnt_r <= free_cnt_nxt_s;
            full_r     <= &valid_nxt_s;
            if (alloc_ok_s) begin
                tstamp_r[free_idx_s] <= now;
            end
        end
    end

    assign alloc_ok  = alloc_ok_s;
    assign alloc_id  = free_idx_s;
    assign valid     = valid_r;
    assign rd_tstamp = tstamp_r[rd_id];
    assign free_cnt  = free_cnt_r;
    assign full      = full_r;

endmodule

// File: rtl/park_fee_unit.sv
// Ticketing and payment stage ahead of the exit bar controller. Issues
// tickets on entry, bills elapsed time on exit, collects coins and emits a
// one-cycle pay pulse once the fee is covered.
module park_fee_unit
    import park_pkg::*;
#(
    parameter int PMAX     = PARK_PMAX,
    parameter int IDW      = 3,
    parameter int TW       = 16,
    parameter int TICK_DIV = 100,
    parameter int RATE     = PARK_RATE,
    parameter int FEE_MIN  = PARK_FEE_MIN,
    parameter int CW       = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           entry_evt,
    input  logic           exit_req,
    input  logic [IDW-1:0] ticket_in,
    input  logic           coin_vld,
    input  logic [7:0]     coin_val,
    input  logic           cancel,
    output logic [IDW-1:0] ticket_id,
    output logic           ticket_vld,
    output logic           full,
    output logic [IDW:0]   free_cnt,
    output logic [CW-1:0]  cost,
    output logic           cost_vld,
    output logic           pay,
    output logic [CW-1:0]  change,
    output logic           err,
    output logic           busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Saturating credit accumulation; a coin never wraps the credit register.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [7:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {{(CW + 1 - 8){1'b0}}, b};
        sat_add = s[CW] ? {CW{1'b1}} : s[CW-1:0];
    endfunction

    logic [1:0]       rst_sync_r;
    logic             rst_int_s;
    logic [PW-1:0]    presc_r;
    logic [TW-1:0]    now_r;
    fee_state_t       state_r;
    fee_state_t       state_nxt_s;
    logic [IDW-1:0]   id_r;
    logic [CW-1:0]    credit_r;
    logic [CW-1:0]    credit_nxt_s;
    logic [CW-1:0]    cost_r;
    logic [CW-1:0]    change_r;
    logic             cost_vld_r;
    logic             pay_r;
    logic             err_r;
    logic             busy_r;
    logic [IDW-1:0]   ticket_id_r;
    logic             ticket_vld_r;
    logic             load_id_s;
    logic             err_nxt_s;
    logic             release_s;
    logic             ticket_ok_s;
    logic             alloc_ok_s;
    logic [IDW-1:0]   alloc_id_s;
    logic [PMAX-1:0]  valid_s;
    logic [TW-1:0]    rd_tstamp_s;
    logic [TW-1:0]    elapsed_s;
    logic [TW-1:0]    units_s;
    logic [TW+31:0]   prod_s;
    logic [CW-1:0]    cost_calc_s;

    // Reset synchronizer: assertion takes effect at once, release waits two clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_s = rst_sync_r[1];

    // Time base: prescaler wraps every TICK_DIV clocks and advances the time counter.
    always_ff @(posedge clk or negedge rst_int_s) begin
        if (!rst_int_s) begin
            presc_r <= {PW{1'b0}};
            now_r   <= {TW{1'b0}};
        end else if (presc_r == PW'(TICK_DIV - 1)) begin
            presc_r <= {PW{1'b0}};
            now_r   <= now_r + TW'(1);
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    park_slot_table #(
        .PMAX (PMAX),
        .IDW  (IDW),
        .TW   (TW)
    ) u_table (
        .clk       (clk),
        .rst       (rst_int_s),
        .alloc_req (entry_evt),
        .now       (now_r),
        .rel_en    (release_s),
        .rel_id    (id_r),
        .rd_id     (id_r),
        .alloc_ok  (alloc_ok_s),
        .alloc_id  (alloc_id_s),
        .valid     (valid_s),
        .rd_tstamp (rd_tstamp_s),
        .free_cnt  (free_cnt),
        .full      (full)
    );

    // A presented ticket is honoured only if it names an existing, occupied slot.
    always_comb begin
        if ({1'b0, ticket_in} < (IDW + 1)'(PMAX)) begin
            ticket_ok_s = valid_s[ticket_in];
        end else begin
            ticket_ok_s = 1'b0;
        end
    end

    // Fee: elapsed time (modulo counter width), floored at FEE_MIN, times RATE, saturated.
    always_comb begin
        elapsed_s = now_r - rd_tstamp_s;
        if (elapsed_s < TW'(FEE_MIN)) begin
            units_s = TW'(FEE_MIN);
        end else begin
            units_s = elapsed_s;
        end
        prod_s = {32'd0, units_s} * (TW + 32)'(RATE);
        if (prod_s > (TW + 32)'({CW{1'b1}})) begin
            cost_calc_s = {CW{1'b1}};
        end else begin
            cost_calc_s = prod_s[CW-1:0];
        end
    end

    // Exit FSM next state; cancel beats the move to PAID, a coin on the move still counts.
    always_comb begin
        state_nxt_s  = state_r;
        credit_nxt_s = credit_r;
        load_id_s    = 1'b0;
        err_nxt_s    = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (exit_req) begin
                    if (ticket_ok_s) begin
                        load_id_s   = 1'b1;
                        state_nxt_s = CALC;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                credit_nxt_s = {CW{1'b0}};
                state_nxt_s  = WAIT_PAY;
            end
            WAIT_PAY: begin
                if (cancel) begin
                    credit_nxt_s = {CW{1'b0}};
                    state_nxt_s  = IDLE;
                end else begin
                    if (coin_vld) begin
                        credit_nxt_s = sat_add(credit_r, coin_val);
                    end else begin
                        credit_nxt_s = credit_r;
                    end
                    if (credit_r >= cost_r) begin
                        state_nxt_s = PAID;
                    end else begin
                        state_nxt_s = WAIT_PAY;
                    end
                end
            end
            PAID: begin
                release_s   = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, latched ticket, credit and the registered transaction outputs.
    always_ff @(posedge clk or negedge rst_int_s) begin
        if (!rst_int_s) begin
            state_r    <= IDLE;
            id_r       <= {IDW{1'b0}};
            credit_r   <= {CW{1'b0}};
            cost_r     <= {CW{1'b0}};
            change_r   <= {CW{1'b0}};
            cost_vld_r <= 1'b0;
            pay_r      <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            credit_r   <= credit_nxt_s;
            err_r      <= err_nxt_s;
            busy_r     <= (state_nxt_s != IDLE);
            cost_vld_r <= (state_nxt_s == WAIT_PAY);
            pay_r      <= (state_nxt_s == PAID);
            if (load_id_s) begin
                id_r <= ticket_in;
            end
            if (state_r == CALC) begin
                cost_r   <= cost_calc_s;
                change_r <= {CW{1'b0}};
            end
            if ((state_r == WAIT_PAY) && (state_nxt_s == PAID)) begin
                change_r <= credit_nxt_s - cost_r;
            end
        end
    end

    // Ticket announcement one cycle after a successful allocation.
    always_ff @(posedge clk or negedge rst_int_s) begin
        if (!rst_int_s) begin
            ticket_id_r  <= {IDW{1'b0}};
            ticket_vld_r <= 1'b0;
        end else begin
            ticket_vld_r <= alloc_ok_s;
            if (alloc_ok_s) begin
                ticket_id_r <= alloc_id_s;
            end
        end
    end

    assign ticket_id  = ticket_id_r;
    assign ticket_vld = ticket_vld_r;
    assign cost       = cost_r;
    assign cost_vld   = cost_vld_r;
    assign pay        = pay_r;
    assign change     = change_r;
    assign err        = err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_park_fee_unit.sv
// Directed bench for park_fee_unit with a scoreboard of expected tickets,
// fees and change, and an independent time-base model.
module tb_park_fee_unit;

    localparam int PMAX = 5;
    localparam int IDW  = 3;
    localparam int TW   = 8;
    localparam int TD   = 4;
    localparam int RATE = 2;
    localparam int FMIN = 1;
    localparam int CW   = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           entry_evt = 1'b0;
    logic           exit_req = 1'b0;
    logic [IDW-1:0] ticket_in = '0;
    logic           coin_vld = 1'b0;
    logic [7:0]     coin_val = '0;
    logic           cancel = 1'b0;
    logic [IDW-1:0] ticket_id;
    logic           ticket_vld;
    logic           full;
    logic [IDW:0]   free_cnt;
    logic [CW-1:0]  cost;
    logic           cost_vld;
    logic           pay;
    logic [CW-1:0]  change;
    logic           err;
    logic           busy;

    always #5 clk = ~clk;

    park_fee_unit #(
        .PMAX(PMAX), .IDW(IDW), .TW(TW), .TICK_DIV(TD),
        .RATE(RATE), .FEE_MIN(FMIN), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .entry_evt(entry_evt), .exit_req(exit_req),
        .ticket_in(ticket_in), .coin_vld(coin_vld), .coin_val(coin_val),
        .cancel(cancel), .ticket_id(ticket_id), .ticket_vld(ticket_vld),
        .full(full), .free_cnt(free_cnt), .cost(cost), .cost_vld(cost_vld),
        .pay(pay), .change(change), .err(err), .busy(busy)
    );

    // Time reference: counting starts two clocks after reset release.
    logic [1:0]    m_rs;
    int            m_pre;
    logic [TW-1:0] m_now;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rs  <= 2'b00;
            m_pre <= 0;
            m_now <= '0;
        end else begin
            m_rs <= {m_rs[0], 1'b1};
            if (m_rs[1]) begin
                if (m_pre == TD - 1) begin
                    m_pre <= 0;
                    m_now <= m_now + 1'b1;
                end else begin
                    m_pre <= m_pre + 1;
                end
            end
        end
    end

    bit            m_valid [PMAX];
    logic [TW-1:0] m_ts [PMAX];
    int            m_cost;
    int            m_credit;
    int            m_id;
    int            id_q[$];
    int            cost_q[$];
    int            change_q[$];
    int            n_tests = 0;
    int            n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < PMAX; i++) if (!m_valid[i]) n++;
        return n;
    endfunction

    task automatic wait_now(input logic [TW-1:0] t);
        int n = 0;
        while (!(m_now == t && m_pre == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_now_in_time", (n < 3000), 1);
    endtask

    task automatic do_entry();
        int slot = -1;
        for (int i = PMAX - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
        entry_evt = 1'b1;
        if (slot >= 0) begin
            m_valid[slot] = 1'b1;
            m_ts[slot]    = m_now;
            id_q.push_back(slot);
        end
        @(negedge clk);
        entry_evt = 1'b0;
        if (slot >= 0) begin
            chk("ticket_vld", ticket_vld, 1);
            chk("ticket_id", ticket_id, id_q.pop_front());
        end else begin
            chk("ticket_vld_when_full", ticket_vld, 0);
        end
    endtask

    task automatic do_exit(input logic [IDW-1:0] id);
        bit ok;
        logic [TW-1:0] el;
        int u;
        ok = (id < PMAX) ? m_valid[id] : 1'b0;
        exit_req  = 1'b1;
        ticket_in = id;
        @(negedge clk);
        exit_req = 1'b0;
        if (ok) begin
            chk("busy_calc", busy, 1);
            chk("cost_vld_calc", cost_vld, 0);
            el = m_now - m_ts[id];
            u = (int'(el) < FMIN) ? FMIN : int'(el);
            m_cost = (u * RATE > 65535) ? 65535 : u * RATE;
            cost_q.push_back(m_cost);
            m_id = id;
            m_credit = 0;
            @(negedge clk);
            chk("cost_vld_wait", cost_vld, 1);
            chk("busy_wait", busy, 1);
            chk("cost", cost, cost_q.pop_front());
        end else begin
            chk("err_pulse", err, 1);
            chk("busy_after_bad", busy, 0);
            @(negedge clk);
            chk("err_one_cycle", err, 0);
        end
    endtask

    task automatic pay_coins(input int c_first, input int c_rest, input bit entry_in_paid);
        int c = c_first;
        int chg;
        for (int k = 0; k < 40; k++) begin
            coin_vld = 1'b1;
            coin_val = c[7:0];
            @(negedge clk);
            coin_vld = 1'b0;
            m_credit = m_credit + c;
            if (m_credit > 65535) m_credit = 65535;
            if (m_credit >= m_cost) break;
            chk("pay_before_cover", pay, 0);
            c = c_rest;
        end
        change_q.push_back(m_credit - m_cost);
        chk("pay_latency_1", pay, 0);
        @(negedge clk);
        chk("pay_pulse", pay, 1);
        chg = change_q.pop_front();
        chk("change", change, chg);
        m_valid[m_id] = 1'b0;
        if (entry_in_paid) entry_evt = 1'b1;
        @(negedge clk);
        entry_evt = 1'b0;
        chk("pay_one_cycle", pay, 0);
        chk("busy_after_pay", busy, 0);
        chk("free_cnt_after_pay", free_cnt, m_free());
        chk("change_held", change, chg);
        if (entry_in_paid) begin
            chk("entry_in_paid_ignored", ticket_vld, 0);
            chk("full_after_release", full, 0);
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        for (int i = 0; i < PMAX; i++) m_valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_free_cnt", free_cnt, PMAX);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_free_cnt", free_cnt, PMAX);
        chk("idle_full", full, 0);
        chk("idle_ticket_vld", ticket_vld, 0);
        chk("idle_pay", pay, 0);
        chk("idle_err", err, 0);
        chk("idle_busy", busy, 0);
        chk("idle_cost_vld", cost_vld, 0);
        chk("idle_cost", cost, 0);
        chk("idle_change", change, 0);

        // Basic ticket / fee / payment round trip.
        do_entry();
        wait_now(8'd7);
        do_exit(3'd0);
        pay_coins(10, 5, 1'b0);

        // Invalid tickets: unused slot and out-of-range ID.
        do_exit(3'd3);
        do_exit(3'd6);

        // Immediate exit bills the minimum.
        wait_now(m_now + 8'd2);
        do_entry();
        do_exit(3'd0);
        pay_coins(2, 2, 1'b0);

        // Fill the table, overflow entry, free a middle slot.
        repeat (5) do_entry();
        chk("full_set", full, 1);
        chk("free_cnt_zero", free_cnt, 0);
        do_entry();
        chk("full_still", full, 1);
        do_exit(3'd2);
        pay_coins(200, 200, 1'b0);

        // Re-enter slot 2 just before the time counter wraps.
        wait_now(8'd254);
        do_entry();
        wait_now(8'd3);
        do_exit(3'd2);

        // Covering coin then cancel in the transition cycle: cancel wins.
        coin_vld = 1'b1;
        coin_val = 8'd20;
        @(negedge clk);
        coin_vld = 1'b0;
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", busy, 0);
        chk("cancel_cost_vld", cost_vld, 0);
        chk("cancel_no_pay", pay, 0);
        @(negedge clk);
        chk("cancel_no_pay_late", pay, 0);
        chk("cancel_slot_kept", free_cnt, 0);

        // Re-request recomputes the fee; entry lands in the PAID cycle while full.
        do_exit(3'd2);
        pay_coins(4, 4, 1'b1);

        // Reset in the middle of WAIT_PAY.
        do_exit(3'd0);
        coin_vld = 1'b1;
        coin_val = 8'd1;
        @(negedge clk);
        coin_vld = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_cost_vld", cost_vld, 0);
        chk("midrst_free_cnt", free_cnt, PMAX);
        chk("midrst_pay", pay, 0);
        for (int i = 0; i < PMAX; i++) m_valid[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_free_cnt", free_cnt, m_free());
        chk("post_rst_cost_vld", cost_vld, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/park_fee_unit.md
Name: park_fee_unit

Overview:
Ticketing and payment stage directly upstream of the car-park bar controller's Pay input.
- Timestamps each entering car into a per-slot table and issues a ticket ID.
- On an exit request, computes the fee from the elapsed time and collects coins.
- When the fee is covered, emits a one-cycle pay pulse that the controller uses to open the exit bar.
- Maintains the free-place count.

Parameters:
PMAX, 5, number of parking slots (table depth)
IDW, 3, ticket ID width; must satisfy 2^IDW >= PMAX
TW, 16, time-counter width in time units
TICK_DIV, 100, clk cycles per time unit (>= 2)
RATE, 2, cost per started time unit
FEE_MIN, 1, minimum billed time units
CW, 16, cost/credit width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
entry_evt  in  1  one-cycle pulse: car passed the entry bar
exit_req  in  1  one-cycle pulse: car at exit presents a ticket
ticket_in  in  IDW  ticket ID; sampled with exit_req
coin_vld  in  1  one-cycle pulse: coin inserted
coin_val  in  8  coin value; sampled with coin_vld
cancel  in  1  abort the current payment
ticket_id  out  IDW  slot assigned to the last entry
ticket_vld  out  1  one-cycle pulse: ticket_id is valid
full  out  1  all slots occupied
free_cnt  out  IDW+1  free places
cost  out  CW  fee of the current exit transaction
cost_vld  out  1  high while waiting for payment
pay  out  1  one-cycle pulse: fee covered; drives the controller's Pay input
change  out  CW  credit minus cost; valid with pay and held until the next CALC
err  out  1  one-cycle pulse: invalid ticket
busy  out  1  exit transaction in progress (FSM not IDLE)

Behaviour:
Reset:
- Asynchronous assertion, synchronous release.
- All outputs are 0, except free_cnt = PMAX.
- Table valid bits, prescaler, time counter, credit and FSM are cleared; FSM is IDLE.
- Reset mid-transaction discards the credit.

Time base:
- The prescaler counts 0..TICK_DIV-1.
- At wrap, now (TW bits) increments, modulo 2^TW.

Entry:
- On entry_evt with full = 0, the lowest-index slot with valid = 0 gets valid <= 1 and tstamp <= now.
- In the next cycle: ticket_id = that slot and ticket_vld = 1.
- On entry_evt with full = 1 the event is ignored: no ticket_vld, no error.
- Entry is independent of the exit FSM; both may happen in the same cycle.

Exit FSM (IDLE, CALC, WAIT_PAY, PAID):
- IDLE:
  - exit_req with ticket_in < PMAX and valid[ticket_in] = 1 -> latch the ID, go to CALC.
  - Any other exit_req -> err pulse next cycle, stay IDLE.
  - exit_req outside IDLE is ignored.
- CALC (1 cycle):
  - elapsed = (now - tstamp) modulo 2^TW.
  - units = max(elapsed, FEE_MIN).
  - cost <= units*RATE, saturating at 2^CW-1.
  - credit <= 0.
  - Go to WAIT_PAY.
- WAIT_PAY:
  - cost_vld = 1.
  - On coin_vld, credit <= credit + coin_val, saturating at 2^CW-1.
  - The comparison credit >= cost uses the registered credit. When true, go to PAID.
  - A coin in the same cycle as the transition is still added to credit, and so to change.
  - cancel -> IDLE; credit discarded; slot stays valid; no pay. cancel has priority over the transition to PAID.
- PAID (1 cycle):
  - pay = 1 and change = credit - cost.
  - valid[ID] <= 0, so free_cnt rises next cycle.
  - Go to IDLE.
- Latency: exit_req to cost_vld = 2 cycles. Covering coin to pay = 2 cycles.

Occupancy:
- free_cnt and full are registered from the valid bits.
- An entry and a PAID slot release in the same cycle net free_cnt unchanged.
- The allocator sees pre-cycle valid bits, so a slot freed in cycle N is first reusable in cycle N+1.

Decomposition:
- Package park_pkg holds:
  - FSM state encodings: IDLE=2'd0, CALC=2'd1, WAIT_PAY=2'd2, PAID=2'd3.
  - Default PMAX, RATE and FEE_MIN, shared with the bar controller.
- Sub-module park_slot_table: valid/tstamp storage, lowest-free priority encoder, free_cnt/full, release port.
- The top level keeps the prescaler, time counter, FSM and credit/cost arithmetic.

Test Plan:
- Reset then idle: free_cnt = 5, full = 0, all pulses 0. Assert rst low mid-WAIT_PAY -> busy = 0, cost_vld = 0 immediately.
- TICK_DIV=4. Entry at now=0 -> ticket 0. Exit_req ticket 0 at now=7 -> cost = 14. Coins 10 then 5 -> pay pulse, change = 1. free_cnt returns to 5.
- Five entries -> tickets 0..4, full = 1, free_cnt = 0. Sixth entry -> no ticket_vld. Pay out ticket 2, then enter -> ticket 2.
- Exit_req with ticket 3 unused, and with ticket 6 -> err pulse each, busy stays 0. Exit_req within 1 time unit of entry -> cost = 2 (FEE_MIN).
- Wrap: entry at now=65534, exit at now=3 -> elapsed 5, cost = 10. cancel in WAIT_PAY -> no pay, slot still valid; re-request -> cost recomputed.
- Simultaneous: entry_evt in the PAID cycle with table full -> entry ignored, slot freed, free_cnt = 1.
